// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle RV32I control FSM.
// Contents: FSM state enum, internal ALU-op selector, ALUControl codes,
// opcode constants, mux-select encodings and the ImmSrc decode helper.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBranch,
        StJal,
        StTrap
    } state_e;

    // What the FSM asks of the ALU decoder.
    typedef enum logic [1:0] {
        AluOpAdd,
        AluOpSub,
        AluOpFunct
    } alu_op_e;

    // ALUControl codes, 4 bits wide; the 3-bit configuration uses the low bits.
    localparam logic [3:0] AluAdd = 4'b0000;
    localparam logic [3:0] AluSub = 4'b0001;
    localparam logic [3:0] AluAnd = 4'b0010;
    localparam logic [3:0] AluOr  = 4'b0011;
    localparam logic [3:0] AluXor = 4'b0100;
    localparam logic [3:0] AluSlt = 4'b0101;
    localparam logic [3:0] AluSll = 4'b1000;
    localparam logic [3:0] AluSrl = 4'b1001;
    localparam logic [3:0] AluSra = 4'b1010;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    localparam logic [1:0] ImmI = 2'b00;
    localparam logic [1:0] ImmS = 2'b01;
    localparam logic [1:0] ImmB = 2'b10;
    localparam logic [1:0] ImmJ = 2'b11;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResData      = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OpStore:  return ImmS;
            OpBranch: return ImmB;
            OpJal:    return ImmJ;
            default:  return ImmI;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath signal bundle.
// master: the controller (takes instruction fields/flags/mem_ready, drives controls).
// slave:  the datapath (drives instruction fields/flags/mem_ready, takes controls).
interface multicycle_controller_if #(
    parameter int unsigned ALU_CTRL_W = 3
);
    logic [6:0]            op;
    logic [2:0]            funct3;
    logic                  funct7b5;
    logic                  Zero;
    logic                  Neg;
    logic                  mem_ready;
    logic                  PCWrite;
    logic                  AdrSrc;
    logic                  MemWrite;
    logic                  IRWrite;
    logic [1:0]            ResultSrc;
    logic [1:0]            ALUSrcA;
    logic [1:0]            ALUSrcB;
    logic [1:0]            ImmSrc;
    logic                  RegWrite;
    logic [ALU_CTRL_W-1:0] ALUControl;
    logic                  illegal_instr;
    logic                  instr_retired;

    modport master (
        input  op, funct3, funct7b5, Zero, Neg, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
               RegWrite, ALUControl, illegal_instr, instr_retired
    );

    modport slave (
        output op, funct3, funct7b5, Zero, Neg, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
               RegWrite, ALUControl, illegal_instr, instr_retired
    );
endinterface

// File: rtl/multicycle_aludec.sv
// Combinational ALU decoder: FSM ALU-op request plus funct fields -> ALUControl.
// Ports: alu_op (FSM request), op5 (opcode bit 5, R-type marker), funct3, funct7b5,
//        alu_control (ALU_CTRL_W-bit operation code).
module multicycle_aludec
    import multicycle_controller_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W = 3
) (
    input  alu_op_e               alu_op,
    input  logic                  op5,
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    output logic [ALU_CTRL_W-1:0] alu_control
);
    logic [3:0] code;

    always_comb begin
        code = AluAdd;
        case (alu_op)
            AluOpSub: code = AluSub;
            AluOpFunct: begin
                case (funct3)
                    // Only R-type subtracts; addi keeps add whatever bit 30 holds.
                    3'b000: code = (op5 && funct7b5) ? AluSub : AluAdd;
                    3'b010: code = AluSlt;
                    3'b100: code = AluXor;
                    3'b110: code = AluOr;
                    3'b111: code = AluAnd;
                    3'b001: if (ALU_CTRL_W >= 4) code = AluSll;
                    3'b101: if (ALU_CTRL_W >= 4) code = funct7b5 ? AluSra : AluSrl;
                    default: code = AluAdd;
                endcase
            end
            default: code = AluAdd;
        endcase
    end

    // Shift codes never occur in the 3-bit build, so truncation is lossless.
    assign alu_control = ALU_CTRL_W'(code);
endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I datapath.
// Sequences Fetch/Decode/Execute/Memory/Writeback, stalls on mem_ready,
// traps on unknown opcodes and pulses instr_retired once per instruction.
// Ports: clk, reset_n (async active-low), bus (controller side of the bundle).
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W = 3,
    parameter bit          EXT_BRANCH = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    multicycle_controller_if.master bus
);
    state_e                state_q, state_d;
    alu_op_e               alu_op;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic                  branch_taken;

    multicycle_aludec #(
        .ALU_CTRL_W(ALU_CTRL_W)
    ) u_aludec (
        .alu_op     (alu_op),
        .op5        (bus.op[5]),
        .funct3     (bus.funct3),
        .funct7b5   (bus.funct7b5),
        .alu_control(alu_control)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= StFetch;
        else          state_q <= state_d;
    end

    always_comb begin
        branch_taken = 1'b0;
        case (bus.funct3)
            3'b000:  branch_taken = bus.Zero;
            3'b001:  branch_taken = EXT_BRANCH && !bus.Zero;
            3'b100:  branch_taken = EXT_BRANCH && bus.Neg;
            3'b101:  branch_taken = EXT_BRANCH && !bus.Neg;
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d           = state_q;
        alu_op            = AluOpAdd;
        bus.PCWrite       = 1'b0;
        bus.AdrSrc        = 1'b0;
        bus.MemWrite      = 1'b0;
        bus.IRWrite       = 1'b0;
        bus.ResultSrc     = ResAluOut;
        bus.ALUSrcA       = SrcAPc;
        bus.ALUSrcB       = SrcBRs2;
        bus.RegWrite      = 1'b0;
        bus.illegal_instr = 1'b0;
        bus.instr_retired = 1'b0;

        case (state_q)
            StFetch: begin
                bus.ALUSrcB   = SrcBFour;
                bus.ResultSrc = ResAluResult;
                // IR load and PC+4 only once memory delivers the word.
                bus.IRWrite   = bus.mem_ready;
                bus.PCWrite   = bus.mem_ready;
                if (bus.mem_ready) state_d = StDecode;
            end
            StDecode: begin
                bus.ALUSrcA = SrcAOldPc;
                bus.ALUSrcB = SrcBImm;
                case (bus.op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpReg:           state_d = StExecR;
                    OpImm:           state_d = StExecI;
                    OpBranch:        state_d = StBranch;
                    OpJal:           state_d = StJal;
                    default:         state_d = StTrap;
                endcase
            end
            StMemAdr: begin
                bus.ALUSrcA = SrcARs1;
                bus.ALUSrcB = SrcBImm;
                state_d     = (bus.op == OpStore) ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                bus.AdrSrc = 1'b1;
                if (bus.mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                bus.ResultSrc     = ResData;
                bus.RegWrite      = 1'b1;
                bus.instr_retired = 1'b1;
                state_d           = StFetch;
            end
            StMemWrite: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
                if (bus.mem_ready) begin
                    bus.instr_retired = 1'b1;
                    state_d           = StFetch;
                end
            end
            StExecR: begin
                bus.ALUSrcA = SrcARs1;
                alu_op      = AluOpFunct;
                state_d     = StAluWb;
            end
            StExecI: begin
                bus.ALUSrcA = SrcARs1;
                bus.ALUSrcB = SrcBImm;
                alu_op      = AluOpFunct;
                state_d     = StAluWb;
            end
            StAluWb: begin
                bus.RegWrite      = 1'b1;
                bus.instr_retired = 1'b1;
                state_d           = StFetch;
            end
            StBranch: begin
                bus.ALUSrcA       = SrcARs1;
                alu_op            = AluOpSub;
                bus.PCWrite       = branch_taken;
                bus.instr_retired = 1'b1;
                state_d           = StFetch;
            end
            StJal: begin
                bus.ALUSrcA = SrcAOldPc;
                bus.ALUSrcB = SrcBFour;
                bus.PCWrite = 1'b1;
                state_d     = StAluWb;
            end
            StTrap: begin
                bus.illegal_instr = 1'b1;
            end
            default: state_d = StFetch;
        endcase

        // Reset overrides everything so no strobe leaks out of an abandoned instruction.
        if (!reset_n) begin
            state_d           = StFetch;
            alu_op            = AluOpAdd;
            bus.PCWrite       = 1'b0;
            bus.AdrSrc        = 1'b0;
            bus.MemWrite      = 1'b0;
            bus.IRWrite       = 1'b0;
            bus.ResultSrc     = ResAluOut;
            bus.ALUSrcA       = SrcAPc;
            bus.ALUSrcB       = SrcBFour;
            bus.RegWrite      = 1'b0;
            bus.illegal_instr = 1'b0;
            bus.instr_retired = 1'b0;
        end
    end

    assign bus.ImmSrc     = reset_n ? imm_src(bus.op) : ImmI;
    assign bus.ALUControl = alu_control;
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: two instances (4-bit ALU + extended branches,
// 3-bit ALU + beq only) run the same instruction stream. Each cycle's expected
// output word is queued as stimulus is applied and checked at the falling edge.
module tb_multicycle_controller;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] RTYPE = 7'b0110011;
    localparam logic [6:0] ITYPE = 7'b0010011;
    localparam logic [6:0] BRA   = 7'b1100011;
    localparam logic [6:0] JALOP = 7'b1101111;
    localparam logic [6:0] BAD   = 7'b1111111;

    typedef enum int {
        XReset, XFetch, XDecode, XMemAdr, XMemRead, XMemWb, XMemWrite,
        XExecR, XExecI, XAluWb, XBranch, XJal, XTrap
    } xst_e;

    typedef struct {
        int          id;
        logic [18:0] exp_a;
        logic [18:0] exp_b;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5, zero, neg, mem_ready;
    logic        rst_lvl;
    logic [6:0]  nxt_op;
    logic [2:0]  nxt_f3;
    logic        nxt_f7, nxt_z, nxt_n;
    logic [18:0] word_a, word_b;
    sb_t         sb_q[$];
    sb_t         mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_cyc   = 0;

    always #5 clk = ~clk;

    multicycle_controller_if #(.ALU_CTRL_W(4)) bus_a ();
    multicycle_controller_if #(.ALU_CTRL_W(3)) bus_b ();

    assign bus_a.op = op;
    assign bus_a.funct3 = funct3;
    assign bus_a.funct7b5 = funct7b5;
    assign bus_a.Zero = zero;
    assign bus_a.Neg = neg;
    assign bus_a.mem_ready = mem_ready;
    assign bus_b.op = op;
    assign bus_b.funct3 = funct3;
    assign bus_b.funct7b5 = funct7b5;
    assign bus_b.Zero = zero;
    assign bus_b.Neg = neg;
    assign bus_b.mem_ready = mem_ready;

    multicycle_controller #(.ALU_CTRL_W(4), .EXT_BRANCH(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a)
    );
    multicycle_controller #(.ALU_CTRL_W(3), .EXT_BRANCH(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b)
    );

    assign word_a = {bus_a.PCWrite, bus_a.AdrSrc, bus_a.MemWrite, bus_a.IRWrite,
                     bus_a.ResultSrc, bus_a.ALUSrcA, bus_a.ALUSrcB, bus_a.ImmSrc,
                     bus_a.RegWrite, bus_a.ALUControl, bus_a.illegal_instr, bus_a.instr_retired};
    assign word_b = {bus_b.PCWrite, bus_b.AdrSrc, bus_b.MemWrite, bus_b.IRWrite,
                     bus_b.ResultSrc, bus_b.ALUSrcA, bus_b.ALUSrcB, bus_b.ImmSrc,
                     bus_b.RegWrite, 1'b0, bus_b.ALUControl, bus_b.illegal_instr,
                     bus_b.instr_retired};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Word layout: PCWrite AdrSrc MemWrite IRWrite ResultSrc ALUSrcA ALUSrcB ImmSrc
    //              RegWrite ALUControl[3:0] illegal_instr instr_retired
    function automatic logic [18:0] exp_word(input xst_e st, input bit mr, input bit take,
                                             input logic [3:0] alu, input logic [1:0] imm);
        logic       pcw, adr, mw, irw, rw, ill, ret;
        logic [1:0] res, sa, sb, im;
        logic [3:0] ac;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0; ret = 0;
        res = 2'b00; sa = 2'b00; sb = 2'b00; ac = 4'b0000; im = imm;
        case (st)
            XReset:    begin sb = 2'b10; im = 2'b00; end
            XFetch:    begin sb = 2'b10; res = 2'b10; irw = mr; pcw = mr; end
            XDecode:   begin sa = 2'b01; sb = 2'b01; end
            XMemAdr:   begin sa = 2'b10; sb = 2'b01; end
            XMemRead:  adr = 1;
            XMemWb:    begin res = 2'b01; rw = 1; ret = 1; end
            XMemWrite: begin adr = 1; mw = 1; ret = mr; end
            XExecR:    begin sa = 2'b10; ac = alu; end
            XExecI:    begin sa = 2'b10; sb = 2'b01; ac = alu; end
            XAluWb:    begin rw = 1; ret = 1; end
            XBranch:   begin sa = 2'b10; ac = 4'b0001; pcw = take; ret = 1; end
            XJal:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            XTrap:     ill = 1;
            default:   ill = 0;
        endcase
        return {pcw, adr, mw, irw, res, sa, sb, im, rw, ac, ill, ret};
    endfunction

    // Applies the pending inputs just after a rising edge and queues what both
    // instances must show for the rest of that cycle.
    task automatic cyc_full(input xst_e st, input bit mr, input logic [1:0] imm,
                            input bit take_a, input bit take_b,
                            input logic [3:0] alu_a, input logic [3:0] alu_b);
        sb_t e;
        @(posedge clk);
        #1;
        reset_n   = rst_lvl;
        mem_ready = mr;
        op        = nxt_op;
        funct3    = nxt_f3;
        funct7b5  = nxt_f7;
        zero      = nxt_z;
        neg       = nxt_n;
        e.id      = n_cyc;
        e.exp_a   = exp_word(st, mr, take_a, alu_a, imm);
        e.exp_b   = exp_word(st, mr, take_b, alu_b, imm);
        n_cyc++;
        sb_q.push_back(e);
    endtask

    task automatic cyc(input xst_e st, input bit mr, input logic [1:0] imm);
        cyc_full(st, mr, imm, 1'b0, 1'b0, 4'b0000, 4'b0000);
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input logic n);
        nxt_op = o; nxt_f3 = f3; nxt_f7 = f7; nxt_z = z; nxt_n = n;
    endtask

    task automatic do_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                          input logic [3:0] alu_a, input logic [3:0] alu_b);
        set_instr(o, f3, f7, 1'b0, 1'b0);
        cyc(XFetch, 1, 2'b00);
        cyc(XDecode, 1, 2'b00);
        cyc_full((o == RTYPE) ? XExecR : XExecI, 1, 2'b00, 1'b0, 1'b0, alu_a, alu_b);
        cyc(XAluWb, 1, 2'b00);
    endtask

    task automatic do_branch(input logic [2:0] f3, input logic z, input logic n,
                             input bit ta, input bit tb);
        set_instr(BRA, f3, 1'b0, z, n);
        cyc(XFetch, 1, 2'b10);
        cyc(XDecode, 1, 2'b10);
        cyc_full(XBranch, 1, 2'b10, ta, tb, 4'b0000, 4'b0000);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check($sformatf("cyc%0d dut_a", mon_e.id), {13'b0, word_a}, {13'b0, mon_e.exp_a});
            check($sformatf("cyc%0d dut_b", mon_e.id), {13'b0, word_b}, {13'b0, mon_e.exp_b});
        end
    end

    initial begin
        rst_lvl = 0; reset_n = 0; mem_ready = 0;
        op = 0; funct3 = 0; funct7b5 = 0; zero = 0; neg = 0;
        set_instr(RTYPE, 3'b000, 1'b0, 1'b0, 1'b0);
        cyc(XReset, 1, 2'b00);
        cyc(XReset, 0, 2'b00);
        rst_lvl = 1;

        // add x3,x1,x2: retires in cycle 4
        do_alu(RTYPE, 3'b000, 1'b0, 4'b0000, 4'b0000);

        // lw: 2 FETCH stalls, 3 MEMREAD stalls -> MEMWB in cycle 10
        set_instr(LOAD, 3'b010, 1'b0, 1'b0, 1'b0);
        cyc(XFetch, 0, 2'b00);
        cyc(XFetch, 0, 2'b00);
        cyc(XFetch, 1, 2'b00);
        cyc(XDecode, 1, 2'b00);
        cyc(XMemAdr, 1, 2'b00);
        for (int i = 0; i < 3; i++) cyc(XMemRead, 0, 2'b00);
        cyc(XMemRead, 1, 2'b00);
        cyc(XMemWb, 1, 2'b00);

        // sw with one write stall
        set_instr(STORE, 3'b010, 1'b0, 1'b0, 1'b0);
        cyc(XFetch, 1, 2'b01);
        cyc(XDecode, 1, 2'b01);
        cyc(XMemAdr, 1, 2'b01);
        cyc(XMemWrite, 0, 2'b01);
        cyc(XMemWrite, 1, 2'b01);

        // Branches: dut_a has extended branches, dut_b only beq
        do_branch(3'b001, 1'b0, 1'b0, 1'b1, 1'b0);  // bne, Zero=0
        do_branch(3'b001, 1'b1, 1'b0, 1'b0, 1'b0);  // bne, Zero=1
        do_branch(3'b100, 1'b0, 1'b1, 1'b1, 1'b0);  // blt, Neg=1
        do_branch(3'b101, 1'b0, 1'b1, 1'b0, 1'b0);  // bge, Neg=1
        do_branch(3'b101, 1'b1, 1'b0, 1'b1, 1'b0);  // bge, Neg=0
        do_branch(3'b000, 1'b1, 1'b0, 1'b1, 1'b1);  // beq, Zero=1
        do_branch(3'b000, 1'b0, 1'b1, 1'b0, 1'b0);  // beq, Zero=0
        do_branch(3'b010, 1'b1, 1'b1, 1'b0, 1'b0);  // unsupported funct3

        // ALU decode, 4-bit vs 3-bit
        do_alu(RTYPE, 3'b101, 1'b1, 4'b1010, 4'b0000);  // sra
        do_alu(RTYPE, 3'b101, 1'b0, 4'b1001, 4'b0000);  // srl
        do_alu(ITYPE, 3'b001, 1'b0, 4'b1000, 4'b0000);  // slli
        do_alu(RTYPE, 3'b000, 1'b1, 4'b0001, 4'b0001);  // sub
        do_alu(ITYPE, 3'b000, 1'b1, 4'b0000, 4'b0000);  // addi, bit30 set
        do_alu(ITYPE, 3'b010, 1'b0, 4'b0101, 4'b0101);  // slti
        do_alu(RTYPE, 3'b111, 1'b0, 4'b0010, 4'b0010);  // and
        do_alu(ITYPE, 3'b110, 1'b0, 4'b0011, 4'b0011);  // ori
        do_alu(RTYPE, 3'b100, 1'b0, 4'b0100, 4'b0100);  // xor

        // jal
        set_instr(JALOP, 3'b000, 1'b0, 1'b0, 1'b0);
        cyc(XFetch, 1, 2'b11);
        cyc(XDecode, 1, 2'b11);
        cyc(XJal, 1, 2'b11);
        cyc(XAluWb, 1, 2'b11);

        // Store interrupted by reset while waiting in MEMWRITE
        set_instr(STORE, 3'b010, 1'b0, 1'b0, 1'b0);
        cyc(XFetch, 1, 2'b01);
        cyc(XDecode, 1, 2'b01);
        cyc(XMemAdr, 1, 2'b01);
        cyc(XMemWrite, 0, 2'b01);
        @(posedge clk);
        #1;
        check("memwrite_held_a", {31'b0, bus_a.MemWrite}, 32'd1);
        check("memwrite_held_b", {31'b0, bus_b.MemWrite}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("memwrite_async_a", {31'b0, bus_a.MemWrite}, 32'd0);
        check("memwrite_async_b", {31'b0, bus_b.MemWrite}, 32'd0);
        check("retire_in_rst_a", {31'b0, bus_a.instr_retired}, 32'd0);
        check("adrsrc_in_rst_a", {31'b0, bus_a.AdrSrc}, 32'd0);
        check("srcb_in_rst_a", {30'b0, bus_a.ALUSrcB}, 32'd2);
        rst_lvl = 0;
        cyc(XReset, 1, 2'b00);
        rst_lvl = 1;
        set_instr(RTYPE, 3'b000, 1'b0, 1'b0, 1'b0);
        do_alu(RTYPE, 3'b000, 1'b0, 4'b0000, 4'b0000);

        // Illegal opcode: TRAP is absorbing and silent until reset
        set_instr(BAD, 3'b000, 1'b0, 1'b0, 1'b0);
        cyc(XFetch, 1, 2'b00);
        cyc(XDecode, 1, 2'b00);
        for (int i = 0; i < 20; i++) cyc(XTrap, i[0], 2'b00);
        rst_lvl = 0;
        cyc(XReset, 1, 2'b00);
        rst_lvl = 1;
        do_alu(ITYPE, 3'b100, 1'b0, 4'b0100, 4'b0100);

        @(negedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
